mux_n_pipe: RTL and testbench

Parametrised N-way, WIDTH-bit registered selector with a valid/ready handshake on every input channel and on the output. It generalises the processor's fixed 2:1 3-bit selectors. It adds a second mode: round-robin arbitration among valid channels, alongside explicit select. It sits between multi-source producers (write-back sources, operand sources) and a single registered consumer, so the selection path is timing-isolated from the consumer.

---
 rtl/mux_n_pipe.sv | 172 +++++++++++++++++
 tb/tb_mux_n_pipe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_pipe.sv
// -----------------------------------------------------------------------------
// mux_n_pipe
//
// Selects one of CHANNELS input channels into a registered output. Every input
// channel and the output use a valid/ready handshake. The channel is picked
// either by an explicit index (rr_mode=0) or by round-robin arbitration over
// the valid channels (rr_mode=1).
//
// Optional feature, enabled by defining the macro MUX_N_PIPE_SKID_EN:
//   a one-entry skid register behind the output entry (capacity 2). With the
//   skid, d_ready no longer has a combinational path from result_ready.
//
// Parameters:
//   WIDTH    - data width per channel
//   CHANNELS - number of input channels (>= 2)
//   SEL_W    - select/grant width (>= ceil(log2(CHANNELS)))
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   d            in   packed channel data, channel i at [i*WIDTH +: WIDTH]
//   d_valid      in   per-channel valid
//   d_ready      out  per-channel accept (one-hot or zero)
//   select       in   explicit channel index (rr_mode=0)
//   rr_mode      in   0 = explicit select, 1 = round-robin
//   result       out  selected data
//   result_valid out  result holds unconsumed data
//   result_ready in   consumer accept
//   grant        out  index of the channel whose data is on result
// -----------------------------------------------------------------------------
module mux_n_pipe #(
    parameter int WIDTH    = 3,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [CHANNELS-1:0]       d_valid,
    output logic [CHANNELS-1:0]       d_ready,
    input  logic [SEL_W-1:0]          select,
    input  logic                      rr_mode,
    output logic [WIDTH-1:0]          result,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [SEL_W-1:0]          grant
);

    logic [WIDTH-1:0] d_arr [CHANNELS];
    logic [SEL_W-1:0] ptr_reg;
    logic [SEL_W-1:0] chosen;
    logic             chosen_ok;
    logic             free;
    logic             transfer;
    logic [WIDTH-1:0] in_data;
    logic [SEL_W-1:0] ptr_next;

    logic [WIDTH-1:0] result_reg;
    logic [SEL_W-1:0] grant_reg;
    logic             valid_reg;

    // Unpack channel data and build the per-channel accept. d_ready is held
    // low while reset is asserted, even though free would otherwise be true.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign d_arr[gi]   = d[gi*WIDTH +: WIDTH];
            assign d_ready[gi] = !reset && free && chosen_ok && (chosen == SEL_W'(gi));
        end
    endgenerate

    // Channel choice. In round-robin mode scan downward so the last hit is
    // the first valid channel at or after ptr (wrapping).
    always_comb begin : p_choose
        int idx;
        idx       = 0;
        chosen    = '0;
        chosen_ok = 1'b0;
        if (!rr_mode) begin
            if (32'(select) < CHANNELS) begin
                chosen    = select;
                chosen_ok = 1'b1;
            end
        end else begin
            for (int k = CHANNELS - 1; k >= 0; k--) begin
                idx = (32'(ptr_reg) + k) % CHANNELS;
                if (d_valid[idx]) begin
                    chosen    = SEL_W'(idx);
                    chosen_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        in_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (chosen == SEL_W'(i)) in_data = d_arr[i];
        end
    end

    assign transfer = |(d_valid & d_ready);
    assign ptr_next = (chosen == SEL_W'(CHANNELS - 1)) ? '0 : chosen + SEL_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (transfer && rr_mode) begin
            ptr_reg <= ptr_next;
        end
    end

`ifdef MUX_N_PIPE_SKID_EN
    logic [WIDTH-1:0] skid_data_reg;
    logic [SEL_W-1:0] skid_grant_reg;
    logic             skid_full_reg;

    // Accepting only depends on the skid slot, so result_ready never reaches
    // d_ready combinationally.
    assign free = !skid_full_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_reg     <= '0;
            grant_reg      <= '0;
            valid_reg      <= 1'b0;
            skid_data_reg  <= '0;
            skid_grant_reg <= '0;
            skid_full_reg  <= 1'b0;
        end else if (skid_full_reg) begin
            // Both entries occupied: no input can transfer; drain in order.
            if (result_ready) begin
                result_reg    <= skid_data_reg;
                grant_reg     <= skid_grant_reg;
                skid_full_reg <= 1'b0;
            end
        end else if (transfer) begin
            if (!valid_reg || result_ready) begin
                result_reg <= in_data;
                grant_reg  <= chosen;
                valid_reg  <= 1'b1;
            end else begin
                skid_data_reg  <= in_data;
                skid_grant_reg <= chosen;
                skid_full_reg  <= 1'b1;
            end
        end else if (valid_reg && result_ready) begin
            valid_reg <= 1'b0;
        end
    end
`else
    assign free = !valid_reg || result_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_reg <= '0;
            grant_reg  <= '0;
            valid_reg  <= 1'b0;
        end else if (transfer) begin
            result_reg <= in_data;
            grant_reg  <= chosen;
            valid_reg  <= 1'b1;
        end else if (result_ready) begin
            valid_reg <= 1'b0;
        end
    end
`endif

    assign result       = result_reg;
    assign grant        = grant_reg;
    assign result_valid = valid_reg;

endmodule

// File: tb/tb_mux_n_pipe.sv
// -----------------------------------------------------------------------------
// tb_mux_n_pipe
//
// Self-checking bench for mux_n_pipe (WIDTH=3, CHANNELS=4, SEL_W=3 so that an
// out-of-range select can be driven). Directed scenarios followed by random
// stimulus, all compared against a queue-based reference model. Works for the
// default build and with MUX_N_PIPE_SKID_EN defined.
// -----------------------------------------------------------------------------
module tb_mux_n_pipe;

    localparam int WIDTH    = 3;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 3;
`ifdef MUX_N_PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic                      clk;
    logic                      reset;
    logic [CHANNELS*WIDTH-1:0] d;
    logic [CHANNELS-1:0]       d_valid;
    logic [CHANNELS-1:0]       d_ready;
    logic [SEL_W-1:0]          select;
    logic                      rr_mode;
    logic [WIDTH-1:0]          result;
    logic                      result_valid;
    logic                      result_ready;
    logic [SEL_W-1:0]          grant;

    mux_n_pipe #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .d            (d),
        .d_valid      (d_valid),
        .d_ready      (d_ready),
        .select       (select),
        .rr_mode      (rr_mode),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .grant        (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: FIFO of pending outputs plus the round-robin pointer.
    int q_res[$];
    int q_gnt[$];
    int ptr_m    = 0;
    int last_res = 0;
    int last_gnt = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_res.delete();
        q_gnt.delete();
        ptr_m    = 0;
        last_res = 0;
        last_gnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".result"}, int'(result), last_res);
        check({tag, ".grant"}, int'(grant), last_gnt);
        check({tag, ".valid"}, int'(result_valid), (q_res.size() > 0) ? 1 : 0);
    endtask

    // One cycle: drive inputs, check d_ready, clock, advance model, check outputs.
    // Entered and left 1 time unit after a rising edge.
    task automatic step(input string tag, input logic [3:0] dv, input logic [11:0] dd,
                        input logic [2:0] sel, input logic rr, input logic rdy);
        int  ch;
        bit  free_m;
        bit  xfer;
        int  exp_ready;
        d_valid      = dv;
        d            = dd;
        select       = sel;
        rr_mode      = rr;
        result_ready = rdy;
        #1;
        ch = -1;
        if (!rr) begin
            if (int'(sel) < CHANNELS) ch = int'(sel);
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (ch < 0 && dv[(ptr_m + k) % CHANNELS]) ch = (ptr_m + k) % CHANNELS;
            end
        end
        if (CAP == 2) free_m = (q_res.size() < 2);
        else          free_m = (q_res.size() == 0) || rdy;
        exp_ready = (free_m && ch >= 0) ? (1 << ch) : 0;
        check({tag, ".d_ready"}, int'(d_ready), exp_ready);
        xfer = free_m && (ch >= 0) && dv[ch];

        @(posedge clk);
        #1;
        if (q_res.size() > 0 && rdy) begin
            void'(q_res.pop_front());
            void'(q_gnt.pop_front());
        end
        if (xfer) begin
            q_res.push_back(int'((dd >> (ch * WIDTH)) & 12'h7));
            q_gnt.push_back(ch);
            if (rr) ptr_m = (ch + 1) % CHANNELS;
        end
        if (q_res.size() > 0) begin
            last_res = q_res[0];
            last_gnt = q_gnt[0];
        end
        check_outputs(tag);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step("drain", 4'b0000, 12'h000, 3'd0, 1'b0, 1'b1);
    endtask

    initial begin
        reset        = 1'b1;
        d            = '0;
        d_valid      = '0;
        select       = '0;
        rr_mode      = 1'b0;
        result_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset.d_ready", int'(d_ready), 0);
        reset = 1'b0;

        // Explicit select: channel 2 carries 3'b101.
        step("explicit", 4'b0100, 12'b000_101_000_000, 3'd2, 1'b0, 1'b1);
        step("sel_oob", 4'b1111, 12'hFFF, 3'd5, 1'b0, 1'b1);

        // Round-robin fairness.
        for (int i = 0; i < 5; i++) step("rr_all", 4'b1111, 12'(i * 291), 3'd0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step("rr_1010", 4'b1010, 12'(i * 1337), 3'd0, 1'b1, 1'b1);
        drain();

        // Backpressure then release.
        step("bp_fill", 4'b0001, 12'h006, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("bp_hold", 4'b1111, 12'hA5C, 3'd1, 1'b0, 1'b0);
        step("bp_release", 4'b1111, 12'hA5C, 3'd1, 1'b0, 1'b1);
        drain();

        // Mode switch preserves ptr.
        step("mode_rr1", 4'b0010, 12'h038, 3'd0, 1'b1, 1'b1);
        step("mode_sel0", 4'b0001, 12'h003, 3'd0, 1'b0, 1'b1);
        step("mode_rr2", 4'b1111, 12'hFAC, 3'd0, 1'b1, 1'b1);
        drain();

        // Two arrivals under stall, then release.
        step("skid1", 4'b0001, 12'h001, 3'd0, 1'b0, 1'b0);
        step("skid2", 4'b0001, 12'h002, 3'd0, 1'b0, 1'b0);
        step("skid3", 4'b0001, 12'h003, 3'd0, 1'b0, 1'b0);
        step("skid_rel1", 4'b0000, 12'h000, 3'd0, 1'b0, 1'b1);
        step("skid_rel2", 4'b0000, 12'h000, 3'd0, 1'b0, 1'b1);
        drain();

        // Mid-stream asynchronous reset with result_valid high.
        step("pre_rst", 4'b1111, 12'hEEE, 3'd0, 1'b1, 1'b0);
        step("pre_rst2", 4'b1111, 12'hDDD, 3'd0, 1'b1, 1'b0);
        #2;
        d_valid = 4'b1111;
        rr_mode = 1'b1;
        reset   = 1'b1;
        #1;
        model_reset();
        check_outputs("midrst");
        check("midrst.d_ready", int'(d_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("post_rst", 4'b1111, 12'h123, 3'd0, 1'b1, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand", 4'($urandom_range(0, 15)), 12'($urandom), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
